// File: rtl/video_timing_pkg.sv
// Shared timing defaults, the 9-bit raster position type, and the window decode used for both syncs.
package video_timing_pkg;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam int DEF_HACT     = 336;
  localparam int DEF_HTOT     = 456;
  localparam int DEF_HS_START = 360;
  localparam int DEF_HS_WIDTH = 24;
  localparam int DEF_VACT     = 240;
  localparam int DEF_VTOT     = 262;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_WIDTH = 3;

  // True when cnt lies in [base, base+width).
  function automatic logic in_window(input pos_t cnt, input int base, input int width);
    int c;
    c = int'(cnt);
    return (c >= base) && (c < base + width);
  endfunction

endpackage

// File: rtl/vt_axis.sv
// One raster axis: position counter, blanking decode and an offset-shifted sync window.
module vt_axis
  import video_timing_pkg::*;
#(
  parameter int TOT     = DEF_HTOT,
  parameter int ACT     = DEF_HACT,
  parameter int S_START = DEF_HS_START,
  parameter int S_WIDTH = DEF_HS_WIDTH,
  parameter int OFFS_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              load,
  input  logic [OFFS_W-1:0] offs,
  output pos_t              cnt,
  output logic              last,
  output logic              blk,
  output logic              syn_n
);

  logic [OFFS_W-1:0] offs_l;

  assign last  = (cnt == pos_t'(TOT - 1));
  assign blk   = (cnt >= pos_t'(ACT));
  // Offset steps are two positions wide.
  assign syn_n = ~in_window(cnt, S_START + 2 * int'(offs_l), S_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      offs_l <= '0;
    end else begin
      if (advance) cnt <= last ? '0 : cnt + pos_t'(1);
      if (load) offs_l <= offs;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator on a pixel clock-enable; offsets are taken only at frame wrap.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HACT     = DEF_HACT,
  parameter int HTOT     = DEF_HTOT,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_WIDTH = DEF_HS_WIDTH,
  parameter int VACT     = DEF_VACT,
  parameter int VTOT     = DEF_VTOT,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_WIDTH = DEF_VS_WIDTH,
  parameter int RGB_W    = 8,
  parameter int HOFFS_W  = 5,
  parameter int VOFFS_W  = 3
) (
  input  logic               MCLK,
  input  logic               RESET_N,
  input  logic               CE_PIX,
  input  logic [HOFFS_W-1:0] HOFFS,
  input  logic [VOFFS_W-1:0] VOFFS,
  input  logic [RGB_W-1:0]   iRGB,
  output logic [8:0]         HPOS,
  output logic [8:0]         VPOS,
  output logic [RGB_W-1:0]   oRGB,
  output logic               HBLK,
  output logic               VBLK,
  output logic               HSYN,
  output logic               VSYN,
  output logic               LINE_START,
  output logic               FRAME_START
);

  if (HS_START + 2 * (2 ** HOFFS_W - 1) + HS_WIDTH > HTOT) begin : g_chk_hsync
    $fatal(1, "video_timing_gen: shifted HSYN window exceeds HTOT");
  end
  if (VS_START + 2 * (2 ** VOFFS_W - 1) + VS_WIDTH > VTOT) begin : g_chk_vsync
    $fatal(1, "video_timing_gen: shifted VSYN window exceeds VTOT");
  end
  if (HACT > HS_START || VACT > VS_START) begin : g_chk_act
    $fatal(1, "video_timing_gen: sync starts inside active area");
  end
  if (HTOT > 512 || VTOT > 512) begin : g_chk_tot
    $fatal(1, "video_timing_gen: totals exceed 9-bit position range");
  end

  pos_t hcnt, vcnt;
  logic h_last, v_last, h_blk, v_blk, h_syn_n, v_syn_n;
  logic line_wrap, frame_wrap;

  assign line_wrap  = CE_PIX & h_last;
  assign frame_wrap = line_wrap & v_last;

  vt_axis #(
    .TOT(HTOT), .ACT(HACT), .S_START(HS_START), .S_WIDTH(HS_WIDTH), .OFFS_W(HOFFS_W)
  ) u_h (
    .clk(MCLK), .rst_n(RESET_N), .advance(CE_PIX), .load(frame_wrap), .offs(HOFFS),
    .cnt(hcnt), .last(h_last), .blk(h_blk), .syn_n(h_syn_n)
  );

  vt_axis #(
    .TOT(VTOT), .ACT(VACT), .S_START(VS_START), .S_WIDTH(VS_WIDTH), .OFFS_W(VOFFS_W)
  ) u_v (
    .clk(MCLK), .rst_n(RESET_N), .advance(line_wrap), .load(frame_wrap), .offs(VOFFS),
    .cnt(vcnt), .last(v_last), .blk(v_blk), .syn_n(v_syn_n)
  );

  assign HPOS = hcnt;
  assign VPOS = vcnt;

  // Decode uses the pre-advance position, so outputs trail HPOS/VPOS by one CE.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      oRGB        <= '0;
      HBLK        <= 1'b1;
      VBLK        <= 1'b1;
      HSYN        <= 1'b1;
      VSYN        <= 1'b1;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      LINE_START  <= line_wrap;
      FRAME_START <= frame_wrap;
      if (CE_PIX) begin
        oRGB <= (h_blk | v_blk) ? '0 : iRGB;
        HBLK <= h_blk;
        VBLK <= v_blk;
        HSYN <= h_syn_n;
        VSYN <= v_syn_n;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int HACT = 16, HTOT = 40, HS_START = 18, HS_WIDTH = 4;
  localparam int VACT = 8, VTOT = 20, VS_START = 10, VS_WIDTH = 2;
  localparam int RGB_W = 8, HOFFS_W = 2, VOFFS_W = 2;
  localparam int FRAME = HTOT * VTOT;

  logic MCLK = 1'b0, RESET_N = 1'b1, CE_PIX = 1'b0;
  logic [HOFFS_W-1:0] HOFFS = '0;
  logic [VOFFS_W-1:0] VOFFS = '0;
  logic [RGB_W-1:0] iRGB = '0;
  logic [8:0] HPOS, VPOS;
  logic [RGB_W-1:0] oRGB;
  logic HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START;

  typedef struct {
    int col;
    int line;
    logic [RGB_W-1:0] rgb;
    logic hblk, vblk, hsyn, vsyn, ls, fs;
  } exp_t;

  exp_t sb[$];
  int mh, mv, mho, mvo;
  int errors = 0, checks = 0;

  video_timing_gen #(
    .HACT(HACT), .HTOT(HTOT), .HS_START(HS_START), .HS_WIDTH(HS_WIDTH),
    .VACT(VACT), .VTOT(VTOT), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH),
    .RGB_W(RGB_W), .HOFFS_W(HOFFS_W), .VOFFS_W(VOFFS_W)
  ) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HOFFS(HOFFS), .VOFFS(VOFFS),
    .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
    .HSYN(HSYN), .VSYN(VSYN), .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  always #5 MCLK = ~MCLK;

  task automatic model_reset();
    mh = 0; mv = 0; mho = 0; mvo = 0;
    sb.delete();
  endtask

  // Drive one MCLK; on a CE push the expected decode of the current position and advance the model.
  task automatic tick(input logic ce);
    exp_t e;
    int hsb, vsb;
    CE_PIX = ce;
    if (ce) begin
      hsb = HS_START + 2 * mho;
      vsb = VS_START + 2 * mvo;
      e.col  = mh;
      e.line = mv;
      e.hblk = (mh >= HACT);
      e.vblk = (mv >= VACT);
      e.hsyn = !(mh >= hsb && mh < hsb + HS_WIDTH);
      e.vsyn = !(mv >= vsb && mv < vsb + VS_WIDTH);
      e.rgb  = (e.hblk || e.vblk) ? '0 : iRGB;
      e.ls   = (mh == HTOT - 1);
      e.fs   = e.ls && (mv == VTOT - 1);
      sb.push_back(e);
      if (mh == HTOT - 1) begin
        mh = 0;
        if (mv == VTOT - 1) begin
          mv = 0; mho = int'(HOFFS); mvo = int'(VOFFS);
        end else mv = mv + 1;
      end else mh = mh + 1;
    end
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START, HPOS, VPOS} !==
        {8'h00, 6'b111100, 18'd0}) begin
      errors++;
      $display("FAIL reset_state: got rgb=%h hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b hpos=%0d vpos=%0d",
               oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START, HPOS, VPOS);
    end
    model_reset();
    @(posedge MCLK); @(posedge MCLK); #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      checks++;
      if ({oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START, HPOS, VPOS} !==
          {8'h00, 6'b111100, 18'd0}) begin
        errors++;
        $display("FAIL reset_hold: got hb=%b vb=%b hs=%b vs=%b hpos=%0d, want reset values",
                 HBLK, VBLK, HSYN, VSYN, HPOS);
      end
    end
    iRGB = 8'h3C;
    tick(1'b1);
    e = sb.pop_front();
    checks++;
    if ({HBLK, VBLK, oRGB, HPOS} !== {1'b0, 1'b0, 8'h3C, 9'd1}) begin
      errors++;
      $display("FAIL first_ce: got hb=%b vb=%b rgb=%h hpos=%0d, want 0 0 3c 1",
               HBLK, VBLK, oRGB, HPOS);
    end
  endtask

  task automatic test_frame_timing();
    exp_t e;
    int ce_cnt = 0, last_fs = -1, last_ls = -1, nfs = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      iRGB = RGB_W'($urandom);
      tick(i % 2 == 0);
      if (i % 2 == 0) begin
        ce_cnt++;
        e = sb.pop_front();
        checks++;
        if ({oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START} !==
            {e.rgb, e.hblk, e.vblk, e.hsyn, e.vsyn, e.ls, e.fs}) begin
          errors++;
          $display("FAIL scoreboard @(%0d,%0d): got rgb=%h hb%b vb%b hs%b vs%b ls%b fs%b want rgb=%h hb%b vb%b hs%b vs%b ls%b fs%b",
                   e.col, e.line, oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START,
                   e.rgb, e.hblk, e.vblk, e.hsyn, e.vsyn, e.ls, e.fs);
        end
        checks++;
        if (HPOS !== 9'(mh) || VPOS !== 9'(mv)) begin
          errors++;
          $display("FAIL position: got %0d,%0d want %0d,%0d", HPOS, VPOS, mh, mv);
        end
        if (LINE_START === 1'b1) begin
          if (last_ls >= 0) begin
            checks++;
            if (ce_cnt - last_ls != HTOT) begin
              errors++;
              $display("FAIL line_period: got %0d CEs want %0d", ce_cnt - last_ls, HTOT);
            end
          end
          last_ls = ce_cnt;
        end
        if (FRAME_START === 1'b1) begin
          nfs++;
          if (last_fs >= 0) begin
            checks++;
            if (ce_cnt - last_fs != FRAME) begin
              errors++;
              $display("FAIL frame_period: got %0d CEs want %0d", ce_cnt - last_fs, FRAME);
            end
          end
          last_fs = ce_cnt;
        end
      end else begin
        checks++;
        if (LINE_START !== 1'b0 || FRAME_START !== 1'b0) begin
          errors++;
          $display("FAIL strobe_no_ce: got ls=%b fs=%b want 0 0", LINE_START, FRAME_START);
        end
      end
    end
    checks++;
    if (nfs < 2) begin
      errors++;
      $display("FAIL frame_count: got %0d FRAME_START pulses want >=2", nfs);
    end
  endtask

  task automatic test_sync(input int ho, input int vo);
    exp_t e;
    bit found = 0;
    int hs_first = -1, hs_last = -1, vs_first = -1, vs_last = -1, hb_first = -1, vb_first = -1;
    HOFFS = HOFFS_W'(ho);
    VOFFS = VOFFS_W'(vo);
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      if (FRAME_START === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_wait_frame: got no FRAME_START within %0d CEs", 2 * FRAME);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      if (e.line == 0 && HSYN === 1'b0) begin
        if (hs_first < 0) hs_first = e.col;
        hs_last = e.col;
      end
      if (e.line == 0 && HBLK === 1'b1 && hb_first < 0) hb_first = e.col;
      if (e.col == 0 && VSYN === 1'b0) begin
        if (vs_first < 0) vs_first = e.line;
        vs_last = e.line;
      end
      if (e.col == 0 && VBLK === 1'b1 && vb_first < 0) vb_first = e.line;
    end
    checks++;
    if (hs_first != HS_START + 2 * ho || hs_last != HS_START + 2 * ho + HS_WIDTH - 1) begin
      errors++;
      $display("FAIL hsync_window ho=%0d: got %0d..%0d want %0d..%0d", ho, hs_first, hs_last,
               HS_START + 2 * ho, HS_START + 2 * ho + HS_WIDTH - 1);
    end
    checks++;
    if (vs_first != VS_START + 2 * vo || vs_last != VS_START + 2 * vo + VS_WIDTH - 1) begin
      errors++;
      $display("FAIL vsync_window vo=%0d: got %0d..%0d want %0d..%0d", vo, vs_first, vs_last,
               VS_START + 2 * vo, VS_START + 2 * vo + VS_WIDTH - 1);
    end
    checks++;
    if (hb_first != HACT || vb_first != VACT) begin
      errors++;
      $display("FAIL blank_start: got h=%0d v=%0d want h=%0d v=%0d", hb_first, vb_first, HACT, VACT);
    end
  endtask

  task automatic test_offset_midframe();
    exp_t e;
    bit new_frame = 0, got_a = 0, got_b = 0;
    int a = -1, b = -1;
    for (int i = 0; i < 2 * FRAME && !got_b; i++) begin
      if (mv == 10 && mh == 0 && !new_frame) HOFFS = HOFFS_W'(2);
      tick(1'b1);
      e = sb.pop_front();
      if (e.fs) new_frame = 1;
      if (!new_frame && e.line == 12 && HSYN === 1'b0 && !got_a) begin a = e.col; got_a = 1; end
      if (new_frame && e.line == 2 && HSYN === 1'b0 && !got_b) begin b = e.col; got_b = 1; end
    end
    checks++;
    if (a != HS_START) begin
      errors++;
      $display("FAIL offset_current_frame: got hsync col %0d want %0d", a, HS_START);
    end
    checks++;
    if (b != HS_START + 4) begin
      errors++;
      $display("FAIL offset_next_frame: got hsync col %0d want %0d", b, HS_START + 4);
    end
    HOFFS = '0;
  endtask

  task automatic test_rgb_hold();
    exp_t e;
    int n_a5 = 0;
    logic [8:0] hp, vp;
    logic [RGB_W+3:0] snap;
    iRGB = 8'hA5;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      checks++;
      if (oRGB !== ((e.col < HACT && e.line < VACT) ? 8'hA5 : 8'h00)) begin
        errors++;
        $display("FAIL rgb_gate @(%0d,%0d): got %h", e.col, e.line, oRGB);
      end
      if (oRGB === 8'hA5) n_a5++;
    end
    checks++;
    if (n_a5 != HACT * VACT) begin
      errors++;
      $display("FAIL rgb_count: got %0d active pixels want %0d", n_a5, HACT * VACT);
    end
    hp = HPOS; vp = VPOS;
    snap = {oRGB, HBLK, VBLK, HSYN, VSYN};
    for (int i = 0; i < 50; i++) begin
      iRGB = RGB_W'($urandom);
      tick(1'b0);
      checks++;
      if (HPOS !== hp || VPOS !== vp || {oRGB, HBLK, VBLK, HSYN, VSYN} !== snap ||
          LINE_START !== 1'b0 || FRAME_START !== 1'b0) begin
        errors++;
        $display("FAIL ce_low_hold: got hpos=%0d vpos=%0d outs=%h want hpos=%0d vpos=%0d outs=%h",
                 HPOS, VPOS, {oRGB, HBLK, VBLK, HSYN, VSYN}, hp, vp, snap);
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int cnt = 0;
    bit got = 0;
    for (int i = 0; i < 2 * FRAME && !(mh == 25 && mv == 12); i++) begin
      tick(1'b1);
      e = sb.pop_front();
    end
    checks++;
    if (HPOS !== 9'd25 || VPOS !== 9'd12) begin
      errors++;
      $display("FAIL midframe_reach: got %0d,%0d want 25,12", HPOS, VPOS);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({oRGB, HBLK, VBLK, HSYN, VSYN, LINE_START, FRAME_START, HPOS, VPOS} !==
        {8'h00, 6'b111100, 18'd0}) begin
      errors++;
      $display("FAIL midframe_reset: got hb=%b vb=%b hs=%b vs=%b hpos=%0d vpos=%0d",
               HBLK, VBLK, HSYN, VSYN, HPOS, VPOS);
    end
    model_reset();
    @(posedge MCLK); #1;
    RESET_N = 1'b1;
    tick(1'b1);
    e = sb.pop_front();
    cnt = 1;
    checks++;
    if (HBLK !== 1'b0 || VBLK !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_decode: got hb=%b vb=%b want 0 0", HBLK, VBLK);
    end
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      if (FRAME_START === 1'b1) got = 1;
      else begin
        tick(1'b1);
        e = sb.pop_front();
        cnt++;
      end
    end
    checks++;
    if (!got || cnt != FRAME) begin
      errors++;
      $display("FAIL post_reset_frame: got FRAME_START after %0d CEs (seen=%0d) want %0d",
               cnt, got, FRAME);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame_timing();
    test_sync(3, 3);
    test_sync(0, 0);
    test_offset_midframe();
    test_rgb_hold();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
